decompressor: RTL and testbench

Inverse of the text `Compressor`: accepts one 1536-bit run-length-coded word and rebuilds the 64-character (512-bit) text block it describes. It sits on the receive side of the compression path, between the compressed-word source and the consumer of the binary text. The block decodes one output byte per clock and hands the block on with a valid/ready handshake.

---
 rtl/decomp_pkg.sv | 20 ++
 rtl/decomp_byte_buffer.sv | 26 ++
 rtl/decompressor.sv | 113 +++++++++++
 tb/tb_decompressor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/decomp_pkg.sv
// Shared constants, token layout and FSM states for the run-length decompressor.
package decomp_pkg;

    localparam int TOKEN_W  = 24;
    localparam int N_TOKENS = 64;
    localparam int N_BYTES  = 64;

    typedef struct packed {
        logic [7:0] len;
        logic [7:0] chr;
        logic [7:0] rsvd;
    } token_t;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE
    } dstate_t;

endpackage

// File: rtl/decomp_byte_buffer.sv
// 64-byte output buffer: synchronous clear, single indexed write port, flat read.
module decomp_byte_buffer
    import decomp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 we,
    input  logic [5:0]           waddr,
    input  logic [7:0]           wdata,
    output logic [N_BYTES*8-1:0] rdata
);

    logic [N_BYTES-1:0][7:0] mem;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem;

endmodule

// File: rtl/decompressor.sv
// Run-length decoder: expands one 64-token word into a 64-byte block, one byte per clock.
// Optional overflow flag port Error is built when DECOMPRESSOR_ERR_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a compressed word, InReady high
// DECODE | writing one byte per cycle until terminator, token exhaustion or full buffer
// DONE   | block valid, held until OutReady
module decompressor
    import decomp_pkg::*;
(
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          InValid,
    output logic                          InReady,
    input  logic [N_TOKENS*TOKEN_W-1:0]   Input,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [N_BYTES*8-1:0]          Output,
    output logic [6:0]                    Length
`ifdef DECOMPRESSOR_ERR_EN
    ,
    output logic                          Error
`endif
);

    dstate_t                    state;
    token_t [N_TOKENS-1:0]      words;
    token_t                     cur;
    logic [6:0]                 tok_idx;
    logic [7:0]                 run_cnt;
    logic [6:0]                 wr_ptr;
    logic                       live;
    logic                       stop;
    logic                       run_last;
    logic                       unused_rsvd;

    assign cur         = words[tok_idx[5:0]];
    assign unused_rsvd = ^cur.rsvd;
    // tok_idx bit 6 set means every token has been consumed
    assign live        = !tok_idx[6] && (cur.len != 8'd0);
    assign stop        = !live || wr_ptr[6];
    assign run_last    = (8'(run_cnt + 8'd1) == cur.len);

    assign InReady  = (state == IDLE) && !RST;
    assign OutValid = (state == DONE);
    assign Length   = wr_ptr;

`ifdef DECOMPRESSOR_ERR_EN
    logic err_q;
    assign Error = err_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            words   <= '0;
            tok_idx <= '0;
            run_cnt <= '0;
            wr_ptr  <= '0;
`ifdef DECOMPRESSOR_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        words   <= Input;
                        tok_idx <= '0;
                        run_cnt <= '0;
                        wr_ptr  <= '0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (stop) begin
                        state <= DONE;
`ifdef DECOMPRESSOR_ERR_EN
                        err_q <= live;
`endif
                    end else begin
                        wr_ptr <= wr_ptr + 7'd1;
                        if (run_last) begin
                            run_cnt <= '0;
                            tok_idx <= tok_idx + 7'd1;
                        end else begin
                            run_cnt <= run_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        state <= IDLE;
`ifdef DECOMPRESSOR_ERR_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    decomp_byte_buffer u_buf (
        .clk   (CLK),
        .rst   (RST),
        .clr   (InReady && InValid),
        .we    ((state == DECODE) && !stop),
        .waddr (wr_ptr[5:0]),
        .wdata (cur.chr),
        .rdata (Output)
    );

endmodule

// File: tb/tb_decompressor.sv
// Directed and random checks of the decompressor against a run-length expansion model.
module tb_decompressor;

    logic           CLK = 1'b0;
    logic           RST;
    logic           InValid;
    logic           InReady;
    logic [1535:0]  Input;
    logic           OutValid;
    logic           OutReady;
    logic [511:0]   Output;
    logic [6:0]     Length;
`ifdef DECOMPRESSOR_ERR_EN
    logic           Error;
`endif

    int checks = 0;
    int errors = 0;
    int tl[64];
    int tc[64];

    decompressor dut (
        .CLK      (CLK),
        .RST      (RST),
        .InValid  (InValid),
        .InReady  (InReady),
        .Input    (Input),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Output   (Output),
        .Length   (Length)
`ifdef DECOMPRESSOR_ERR_EN
        ,
        .Error    (Error)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1535:0] build();
        logic [1535:0] w;
        for (int k = 0; k < 64; k++)
            w[24*k +: 24] = {tl[k][7:0], tc[k][7:0], 8'($urandom)};
        return w;
    endfunction

    // Expand runs in order, stopping at a zero length, token exhaustion or 64 bytes.
    task automatic model(output logic [511:0] eb, output int n, output bit ovf);
        eb  = '0;
        n   = 0;
        ovf = 1'b0;
        for (int k = 0; k < 64 && !ovf; k++) begin
            if (tl[k] == 0) break;
            for (int r = 0; r < tl[k]; r++) begin
                if (n == 64) begin
                    ovf = 1'b1;
                    break;
                end
                eb[8*n +: 8] = tc[k][7:0];
                n++;
            end
        end
    endtask

    task automatic fill_tokens(input int mode);
        int nt;
        for (int k = 0; k < 64; k++) begin
            tc[k] = $urandom_range(0, 255);
            tl[k] = 0;
        end
        case (mode)
            0: begin
                nt = $urandom_range(0, 10);
                for (int k = 0; k < nt; k++) tl[k] = $urandom_range(1, 5);
            end
            1: for (int k = 0; k < 64; k++) tl[k] = $urandom_range(0, 20);
            2: for (int k = 0; k < 4; k++) tl[k] = $urandom_range(1, 255);
            default: for (int k = 0; k < 64; k++) tl[k] = 1;
        endcase
    endtask

    task automatic run_word(input string tag, input bit hold);
        logic [511:0] eb;
        int n;
        bit ovf;
        int lat;
        int waitc;
        int ready_hi;
        model(eb, n, ovf);
        Input   = build();
        InValid = 1'b1;
        waitc   = 0;
        while (!InReady && waitc < 200) begin
            @(posedge CLK); #1;
            waitc++;
        end
        chk({tag, ":in_ready"}, 512'(InReady), 512'(1));
        @(posedge CLK); #1;
        InValid  = 1'b0;
        Input    = {48{32'($urandom)}};
        lat      = 0;
        ready_hi = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
            if (!OutValid && InReady) ready_hi++;
        end while (!OutValid && lat < 300);
        chk({tag, ":latency"}, 512'(lat), 512'(n + 1));
        chk({tag, ":busy_ready"}, 512'(ready_hi), 512'(0));
        chk({tag, ":output"}, Output, eb);
        chk({tag, ":length"}, 512'(Length), 512'(n));
`ifdef DECOMPRESSOR_ERR_EN
        chk({tag, ":error"}, 512'(Error), 512'(ovf));
`endif
        if (hold) begin
            OutReady = 1'b0;
            InValid  = 1'b1;
            repeat (10) begin
                @(posedge CLK); #1;
                chk({tag, ":hold_output"}, Output, eb);
                chk({tag, ":hold_valid"}, 512'(OutValid), 512'(1));
                chk({tag, ":hold_ready"}, 512'(InReady), 512'(0));
            end
            OutReady = 1'b1;
        end
        @(posedge CLK); #1;
        chk({tag, ":released"}, 512'(OutValid), 512'(0));
        chk({tag, ":ready_after"}, 512'(InReady), 512'(1));
        InValid = 1'b0;
    endtask

    initial begin
        logic [511:0] eb;
        int n;
        bit ovf;
        int waitc;

        RST      = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b1;
        Input    = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", 512'(InReady), 512'(0));
        chk("rst_out_valid", 512'(OutValid), 512'(0));
        chk("rst_output", Output, 512'(0));
        chk("rst_length", 512'(Length), 512'(0));
`ifdef DECOMPRESSOR_ERR_EN
        chk("rst_error", 512'(Error), 512'(0));
`endif
        RST = 1'b0;
        #1;
        chk("rst_release_ready", 512'(InReady), 512'(1));

        fill_tokens(-1);
        for (int k = 0; k < 64; k++) tl[k] = 0;
        tl[0] = 64; tc[0] = 8'h41;
        run_word("single_run", 1'b0);

        fill_tokens(-1);
        for (int k = 0; k < 64; k++) tl[k] = 0;
        tl[0] = 3; tc[0] = 8'h61;
        tl[1] = 2; tc[1] = 8'h62;
        run_word("mixed_runs", 1'b0);

        fill_tokens(-1);
        for (int k = 0; k < 64; k++) tl[k] = 0;
        tl[0] = 60; tc[0] = 8'h78;
        tl[1] = 10; tc[1] = 8'h79;
        run_word("overflow", 1'b0);

        fill_tokens(0);
        for (int k = 0; k < 64; k++) tl[k] = 0;
        run_word("empty", 1'b0);

        fill_tokens(3);
        run_word("exhaust", 1'b0);

        fill_tokens(0);
        tl[0] = 4; tl[1] = 0;
        run_word("backpressure", 1'b1);
        fill_tokens(1);
        run_word("after_hold", 1'b0);

        for (int i = 0; i < 20; i++) begin
            fill_tokens($urandom_range(0, 3));
            run_word("random", 1'b0);
        end

        fill_tokens(-1);
        for (int k = 0; k < 64; k++) tl[k] = 0;
        tl[0] = 64; tc[0] = 8'h41;
        Input   = build();
        InValid = 1'b1;
        waitc   = 0;
        while (!InReady && waitc < 200) begin
            @(posedge CLK); #1;
            waitc++;
        end
        chk("mid_rst_accept_ready", 512'(InReady), 512'(1));
        @(posedge CLK); #1;
        InValid = 1'b0;
        repeat (19) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("mid_rst_out_valid", 512'(OutValid), 512'(0));
        chk("mid_rst_output", Output, 512'(0));
        chk("mid_rst_length", 512'(Length), 512'(0));
        RST = 1'b0;
        #1;
        chk("mid_rst_idle", 512'(InReady), 512'(1));

        fill_tokens(-1);
        for (int k = 0; k < 64; k++) tl[k] = 0;
        tl[0] = 3; tc[0] = 8'h61;
        tl[1] = 2; tc[1] = 8'h62;
        model(eb, n, ovf);
        chk("model_mixed_len", 512'(n), 512'(5));
        run_word("post_reset", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
